// File: rtl/grade_pkg.sv
// Shared types for the DFA equivalence checker: FSM encoding, default widths
// and the symbol-counter width.
package grade_pkg;

  localparam int DEF_STATE_W = 3;
  localparam int DEF_SYM_W   = 1;
  localparam int SYM_COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } fsm_state_e;

  typedef logic [DEF_STATE_W-1:0] state_t;
  typedef logic [DEF_SYM_W-1:0]   sym_t;
  typedef logic [SYM_COUNT_W-1:0] sym_count_t;

endpackage

// File: rtl/dfa_table.sv
// One programmable DFA: next-state table, accept bits and current-state register.
// Reset clears the table so every state becomes a non-accepting sink to state 0.
module dfa_table
  import grade_pkg::*;
#(
  parameter int STATE_W    = DEF_STATE_W,
  parameter int SYM_W      = DEF_SYM_W,
  parameter int INIT_STATE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic               cfg_acc_we,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [SYM_W-1:0]   cfg_sym,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic               cfg_accept,
  input  logic               init,
  input  logic               step,
  input  logic [SYM_W-1:0]   sym,
  output logic               accept
);

  localparam int NS = 1 << STATE_W;
  localparam int NA = 1 << SYM_W;

  logic [STATE_W-1:0] r_next [NS][NA];
  logic [NS-1:0]      r_acc;
  logic [STATE_W-1:0] r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NS; i++)
        for (int j = 0; j < NA; j++)
          r_next[i][j] <= '0;
      r_acc   <= '0;
      r_state <= STATE_W'(INIT_STATE);
    end else begin
      if (cfg_we)
        r_next[cfg_state][cfg_sym] <= cfg_next;
      if (cfg_acc_we)
        r_acc[cfg_state] <= cfg_accept;
      if (init)
        r_state <= STATE_W'(INIT_STATE);
      else if (step)
        r_state <= r_next[r_state][sym];
    end
  end

  assign accept = r_acc[r_state];

endmodule

// File: rtl/dfa_equiv_checker.sv
// Lockstep equivalence checker for two programmable DFAs with first-divergence
// detection. Optional counterexample capture buffer: define CE_CAPTURE_EN.
module dfa_equiv_checker
  import grade_pkg::*;
#(
  parameter int STATE_W    = DEF_STATE_W,
  parameter int SYM_W      = DEF_SYM_W,
  parameter int INIT_STATE = 1,
  parameter int CE_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic                        cfg_acc_we,
  input  logic                        cfg_sel,
  input  logic [STATE_W-1:0]          cfg_state,
  input  logic [SYM_W-1:0]            cfg_sym,
  input  logic [STATE_W-1:0]          cfg_next,
  input  logic                        cfg_accept,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        sym_valid,
  input  logic [SYM_W-1:0]            sym,
  output logic                        sym_ready,
  output logic                        out_a,
  output logic                        out_b,
  output logic                        busy,
  output logic                        mismatch,
  output logic [SYM_COUNT_W-1:0]      sym_count,
  output logic [$clog2(CE_DEPTH):0]   ce_len,
  input  logic [$clog2(CE_DEPTH)-1:0] ce_rd_idx,
  output logic [SYM_W-1:0]            ce_rd_sym
);

  fsm_state_e r_fsm;
  logic       r_mismatch;
  sym_count_t r_cnt;
  logic       w_diff, w_idle, w_step;

  assign w_idle    = (r_fsm == IDLE);
  assign w_diff    = (out_a != out_b);
  assign sym_ready = (r_fsm == RUN) && !w_diff;
  // start and stop take priority over consuming a symbol in the same cycle
  assign w_step    = sym_ready && sym_valid && !start && !stop;

  dfa_table #(.STATE_W(STATE_W), .SYM_W(SYM_W), .INIT_STATE(INIT_STATE)) u_dfa_a (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we && w_idle && !cfg_sel), .cfg_acc_we(cfg_acc_we && w_idle && !cfg_sel),
    .cfg_state(cfg_state), .cfg_sym(cfg_sym), .cfg_next(cfg_next), .cfg_accept(cfg_accept),
    .init(start), .step(w_step), .sym(sym), .accept(out_a)
  );

  dfa_table #(.STATE_W(STATE_W), .SYM_W(SYM_W), .INIT_STATE(INIT_STATE)) u_dfa_b (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we && w_idle && cfg_sel), .cfg_acc_we(cfg_acc_we && w_idle && cfg_sel),
    .cfg_state(cfg_state), .cfg_sym(cfg_sym), .cfg_next(cfg_next), .cfg_accept(cfg_accept),
    .init(start), .step(w_step), .sym(sym), .accept(out_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm      <= IDLE;
      r_mismatch <= 1'b0;
    end else if (start) begin
      r_fsm      <= RUN;
      r_mismatch <= 1'b0;
    end else begin
      unique case (r_fsm)
        IDLE: r_fsm <= IDLE;
        RUN: begin
          if (stop) begin
            r_fsm <= IDLE;
          end else if (w_diff) begin
            r_fsm      <= FAIL;
            r_mismatch <= 1'b1;
          end
        end
        FAIL: if (stop) r_fsm <= IDLE;
        default: r_fsm <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start)
      r_cnt <= '0;
    else if (w_step && (r_cnt != '1))
      r_cnt <= r_cnt + SYM_COUNT_W'(1);
  end

  assign busy      = (r_fsm == RUN);
  assign mismatch  = r_mismatch;
  assign sym_count = r_cnt;

`ifdef CE_CAPTURE_EN
  localparam int CE_AW = $clog2(CE_DEPTH);

  logic [SYM_W-1:0] r_ce_mem [CE_DEPTH];
  logic [CE_AW-1:0] r_ce_wp;
  logic [CE_AW:0]   r_ce_len;
  logic [CE_AW-1:0] w_ce_base, w_ce_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CE_DEPTH; i++)
        r_ce_mem[i] <= '0;
      r_ce_wp  <= '0;
      r_ce_len <= '0;
    end else if (start) begin
      r_ce_wp  <= '0;
      r_ce_len <= '0;
    end else if (w_step) begin
      r_ce_mem[r_ce_wp] <= sym;
      r_ce_wp           <= r_ce_wp + CE_AW'(1);
      if (r_ce_len != (CE_AW+1)'(CE_DEPTH))
        r_ce_len <= r_ce_len + (CE_AW+1)'(1);
    end
  end

  // Once full, the write pointer points at the oldest retained entry
  assign w_ce_base = (r_ce_len == (CE_AW+1)'(CE_DEPTH)) ? r_ce_wp : '0;
  assign w_ce_addr = w_ce_base + ce_rd_idx;
  assign ce_rd_sym = r_ce_mem[w_ce_addr];
  assign ce_len    = r_ce_len;
`else
  logic w_unused_rd_idx;
  assign w_unused_rd_idx = ^ce_rd_idx;
  assign ce_len          = '0;
  assign ce_rd_sym       = '0;
`endif

endmodule

// File: tb/tb_dfa_equiv_checker.sv
// Directed bench for dfa_equiv_checker; expectations adapt to CE_CAPTURE_EN.
`timescale 1ns/1ps
module tb_dfa_equiv_checker;
  import grade_pkg::*;

`ifdef CE_CAPTURE_EN
  localparam bit CE_ON = 1'b1;
`else
  localparam bit CE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0, cfg_we = 1'b0, cfg_acc_we = 1'b0, cfg_sel = 1'b0;
  logic [2:0] cfg_state = '0, cfg_next = '0;
  logic [0:0] cfg_sym = '0, sym = '0, ce_rd_sym;
  logic       cfg_accept = 1'b0, start = 1'b0, stop = 1'b0, sym_valid = 1'b0;
  logic       sym_ready, out_a, out_b, busy, mismatch;
  logic [15:0] sym_count;
  logic [3:0]  ce_len;
  logic [2:0]  ce_rd_idx = '0;

  int n_tests = 0;
  int n_fail  = 0;

  dfa_equiv_checker #(.STATE_W(3), .SYM_W(1), .INIT_STATE(1), .CE_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_acc_we(cfg_acc_we), .cfg_sel(cfg_sel),
    .cfg_state(cfg_state), .cfg_sym(cfg_sym), .cfg_next(cfg_next), .cfg_accept(cfg_accept),
    .start(start), .stop(stop), .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
    .out_a(out_a), .out_b(out_b), .busy(busy), .mismatch(mismatch), .sym_count(sym_count),
    .ce_len(ce_len), .ce_rd_idx(ce_rd_idx), .ce_rd_sym(ce_rd_sym)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic cfg_nx(input logic sel, input logic [2:0] st, input logic s, input logic [2:0] nx);
    cfg_sel = sel; cfg_state = st; cfg_sym = s; cfg_next = nx; cfg_we = 1'b1;
    tick(); cfg_we = 1'b0;
  endtask

  task automatic cfg_acc(input logic sel, input logic [2:0] st, input logic a);
    cfg_sel = sel; cfg_state = st; cfg_accept = a; cfg_acc_we = 1'b1;
    tick(); cfg_acc_we = 1'b0;
  endtask

  // "last symbol is 1": state 1 = last was 0 (or empty), state 2 = last was 1
  task automatic prog_ends1(input logic sel);
    cfg_nx(sel, 3'd1, 1'b0, 3'd1); cfg_nx(sel, 3'd1, 1'b1, 3'd2);
    cfg_nx(sel, 3'd2, 1'b0, 3'd1); cfg_nx(sel, 3'd2, 1'b1, 3'd2);
    cfg_acc(sel, 3'd2, 1'b1);
  endtask

  // Same language, except a trailing "11" lands in rejecting state 3
  task automatic prog_b_11();
    cfg_nx(1'b1, 3'd1, 1'b0, 3'd1); cfg_nx(1'b1, 3'd1, 1'b1, 3'd2);
    cfg_nx(1'b1, 3'd2, 1'b0, 3'd1); cfg_nx(1'b1, 3'd2, 1'b1, 3'd3);
    cfg_nx(1'b1, 3'd3, 1'b0, 3'd1); cfg_nx(1'b1, 3'd3, 1'b1, 3'd3);
    cfg_acc(1'b1, 3'd2, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic feed(input logic s);
    sym_valid = 1'b1; sym = s; tick(); sym_valid = 1'b0;
  endtask

  logic [19:0] pat;
  logic [9:0]  seq;

  initial begin
    pat = 20'b1011_0010_1110_0101_0011;
    seq = 10'b11_0010_0100;  // seq[i] is symbol i: 0,0,1,0,0,1,0,0,1,1

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_count", sym_count, 0);
    chk("rst_ce_len", ce_len, 0);
    chk("rst_ready", sym_ready, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);

    // Identical automata over a 20-symbol stream
    prog_ends1(1'b0); prog_ends1(1'b1);
    pulse_start();
    chk("t1_busy_start", busy, 1);
    chk("t1_ready", sym_ready, 1);
    for (int i = 0; i < 20; i++) begin
      feed(pat[i]);
      chk($sformatf("t1_out_a_%0d", i), out_a, 32'(pat[i]));
    end
    chk("t1_mismatch", mismatch, 0);
    chk("t1_count", sym_count, 20);
    chk("t1_busy", busy, 1);
    chk("t1_ce_len", ce_len, CE_ON ? 8 : 0);

    // Config write while running must be ignored: A would reject "11" otherwise
    cfg_nx(1'b0, 3'd2, 1'b1, 3'd1);
    feed(1'b1); feed(1'b1);
    chk("t5_out_a", out_a, 1);
    tick();
    chk("t5_mismatch", mismatch, 0);
    chk("t5_count", sym_count, 22);

    // Reset mid-run
    do_reset();
    chk("t5r_busy", busy, 0);
    chk("t5r_count", sym_count, 0);
    chk("t5r_ce_len", ce_len, 0);
    chk("t5r_out_a", out_a, 0);
    chk("t5r_ready", sym_ready, 0);
    pulse_start();
    feed(1'b1);
    chk("t5r_zero_tbl_out_a", out_a, 0);
    chk("t5r_zero_tbl_count", sym_count, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t5r_stop_busy", busy, 0);

    // Divergence on "11"
    do_reset();
    prog_ends1(1'b0); prog_b_11();
    pulse_start();
    feed(1'b1);
    chk("t2_out_a1", out_a, 1);
    chk("t2_out_b1", out_b, 1);
    feed(1'b1);
    chk("t2_out_a2", out_a, 1);
    chk("t2_out_b2", out_b, 0);
    chk("t2_mm_not_yet", mismatch, 0);
    chk("t2_ready0", sym_ready, 0);
    feed(1'b0);
    chk("t2_mismatch", mismatch, 1);
    chk("t2_busy", busy, 0);
    chk("t2_count", sym_count, 2);
    chk("t2_ce_len", ce_len, CE_ON ? 2 : 0);
    ce_rd_idx = 3'd0; #1;
    chk("t2_ce0", ce_rd_sym, CE_ON ? 1 : 0);
    ce_rd_idx = 3'd1; #1;
    chk("t2_ce1", ce_rd_sym, CE_ON ? 1 : 0);
    feed(1'b1);
    chk("t2_hold_count", sym_count, 2);
    chk("t2_hold_mm", mismatch, 1);

    // Restart from FAIL
    pulse_start();
    chk("t6_busy", busy, 1);
    chk("t6_mismatch", mismatch, 0);
    chk("t6_count", sym_count, 0);
    chk("t6_ce_len", ce_len, 0);
    chk("t6_out_a", out_a, 0);
    chk("t6_out_b", out_b, 0);

    // Empty-string divergence
    do_reset();
    cfg_acc(1'b0, 3'd1, 1'b1);
    sym_valid = 1'b1; sym = 1'b1;
    pulse_start();
    chk("t3_busy", busy, 1);
    chk("t3_ready", sym_ready, 0);
    chk("t3_mm_not_yet", mismatch, 0);
    tick();
    chk("t3_mismatch", mismatch, 1);
    chk("t3_count", sym_count, 0);
    chk("t3_ready_fail", sym_ready, 0);
    sym_valid = 1'b0;

    // Buffer wrap: 10 symbols, divergence on the trailing "11"
    do_reset();
    prog_ends1(1'b0); prog_b_11();
    pulse_start();
    for (int i = 0; i < 10; i++) feed(seq[i]);
    chk("t4_ready0", sym_ready, 0);
    feed(1'b0);
    chk("t4_mismatch", mismatch, 1);
    chk("t4_count", sym_count, 10);
    chk("t4_ce_len", ce_len, CE_ON ? 8 : 0);
    for (int k = 0; k < 8; k++) begin
      ce_rd_idx = 3'(k); #1;
      chk($sformatf("t4_ce%0d", k), ce_rd_sym, CE_ON ? 32'(seq[k+2]) : 0);
    end

    // stop from FAIL keeps results
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t4_stop_busy", busy, 0);
    chk("t4_stop_mm", mismatch, 1);
    chk("t4_stop_count", sym_count, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dfa_equiv_checker.md
# dfa_equiv_checker

Parametrised, runtime-programmable equivalence checker for two deterministic finite automata (A = reference solution, B = submitted solution). Both transition tables and accept sets are loaded through a configuration port, then both machines are stepped in lockstep on a shared symbol stream. The block flags the first input prefix on which their accept outputs differ and reports its length. It generalises the fixed two-automaton equality harness to arbitrary state count and alphabet width, and adds counterexample capture.

## Interface
- STATE_W, 3: state encoding width; 2^STATE_W states per automaton.
- SYM_W, 1: symbol width; 2^SYM_W alphabet symbols.
- INIT_STATE, 1: start state of both automata.
- CE_DEPTH, 8: counterexample buffer depth (power of 2, ≥2).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  write next-state entry (cfg_sel, cfg_state, cfg_sym) ← cfg_next.
- cfg_acc_we  in  1  write accept bit (cfg_sel, cfg_state) ← cfg_accept.
- cfg_sel  in  1  0 = automaton A, 1 = automaton B.
- cfg_state  in  STATE_W  table row.
- cfg_sym  in  SYM_W  table column.
- cfg_next  in  STATE_W  next-state data.
- cfg_accept  in  1  accept-bit data.
- start  in  1  begin/restart a run.
- stop  in  1  abort to IDLE.
- sym_valid  in  1  symbol present.
- sym  in  SYM_W  input symbol.
- sym_ready  out  1  symbol will be consumed this cycle.
- out_a, out_b  out  1  accept bit of current A/B state.
- busy  out  1  FSM in RUN.
- mismatch  out  1  sticky; set on divergence.
- sym_count  out  16  symbols consumed this run, saturating at 0xFFFF.
- ce_len  out  $clog2(CE_DEPTH)+1  valid entries in counterexample buffer.
- ce_rd_idx  in  $clog2(CE_DEPTH)  buffer read index, 0 = oldest.
- ce_rd_sym  out  SYM_W  combinational read of entry ce_rd_idx.

## Operation
- FSM states: IDLE, RUN, FAIL.
- reset: FSM→IDLE; both state registers←INIT_STATE; all table entries←0 (state 0 = non-accepting self-loop sink); all accept bits←0; mismatch=0, sym_count=0, ce_len=0; sym_ready=0, busy=0.
- cfg_we/cfg_acc_we honoured only in IDLE; ignored in RUN/FAIL. Both in one cycle: both writes performed.
- out_a/out_b = accept[state] combinational, valid in all FSM states.
- diff = (out_a != out_b).
- IDLE: start → RUN; state_a, state_b ← INIT_STATE; sym_count, ce_len, mismatch ← 0.
- RUN: sym_ready = !diff. If diff: → FAIL, mismatch←1, states frozen. Else if sym_valid: state_x ← next_x[state_x][sym], sym_count++, symbol pushed to buffer.
- FAIL: states, sym_count, buffer frozen; mismatch held.
- start in RUN or FAIL: restart as from IDLE (start beats stop). stop in RUN/FAIL → IDLE, results held.
- Empty-string divergence (accept[INIT_STATE] differs) reports mismatch with sym_count=0.
- sym_count saturates; the run continues.

## Timing
- Symbol consumed at edge N → new states and out_a/out_b visible after N; mismatch asserted at edge N+1 if they differ.
- start at edge N → busy=1 after N; empty-string mismatch at edge N+1.
- Symbols presented while sym_ready=0 are dropped, never counted.
- reset overrides everything, including an in-progress run.

## Configuration
- CE_CAPTURE_EN defined: CE_DEPTH-entry circular buffer of consumed symbols. Write pointer wraps; ce_len = min(sym_count, CE_DEPTH); ce_rd_idx 0 = oldest retained symbol. Frozen in FAIL, so after a mismatch it holds the tail of the counterexample.
- Undefined: no buffer storage; ce_len and ce_rd_sym tied to 0; ports remain.

## Structure
- grade_pkg: fsm_state_e enum (IDLE/RUN/FAIL), state/symbol typedefs, SYM_COUNT_W = 16.
- Sub-module dfa_table: one table plus accept array and state register, with config write port, step, and init. Instantiated twice; the checker adds FSM, comparator, counter, and buffer.

## Test plan
- Identical A/B ("last symbol is 1", 2 states), 20 random symbols → mismatch=0, sym_count=20, busy=1.
- A = "ends in 1"; B = same except "11" rejects; feed 1,1 → mismatch at edge after 2nd symbol, sym_count=2, ce_len=2, entries {1,1}, FAIL holds.
- accept_a[1]=1, accept_b[1]=0; start → mismatch next cycle, sym_count=0, sym_ready never 1.
- CE_DEPTH=8, feed 10 distinct-pattern symbols then force mismatch → ce_len=8, ce_rd_idx 0 returns symbol #3.
- cfg_we during RUN alters nothing; reset mid-run → IDLE, tables zero, outputs at reset values.
- Restart from FAIL with start → mismatch cleared, sym_count=0, states=INIT_STATE.
